instr_mem_loader: RTL and testbench
===================================

// Module: instr_mem_loader
// PURPOSE
// Boot-time loader sitting upstream of the core/instruction-memory pair. Accepts a byte
// stream (valid/ready), packs bytes little-endian into 32-bit words, writes them to
// consecutive instruction-memory addresses from 0, and holds the core in reset until the
// image is complete. It replaces the bench-side memory preload and gives the core a
// synthesizable program-load path.
// PARAMETERS
// ADDR_WIDTH  10    word-address width of instruction memory; depth = 2**ADDR_WIDTH words
// PORTS
// clk          in   1             system clock, rising edge
// rst_n        in   1             asynchronous active-low reset
// start        in   1             1-cycle pulse: begin a load of num_words words
// num_words    in   ADDR_WIDTH+1  words to load; sampled on the start cycle
// byte_valid   in   1             byte_data valid
// byte_data    in   8             next image byte, little-endian within each word
// byte_ready   out  1             loader accepts byte this cycle (transfer = valid & ready)
// mem_we       out  1             instruction-memory write strobe, 1 cycle per word
// mem_addr     out  ADDR_WIDTH    word address for the write
// mem_wdata    out  32            assembled word
// core_rst_n   out  1             active-low reset to core; low until a load completes
// busy         out  1             high in LOAD or WRITE
// done         out  1             high in DONE; stays high until next accepted start
// err          out  1             sticky: num_words > 2**ADDR_WIDTH; cleared on next accepted start
// BEHAVIOUR
// - Reset values: byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_rst_n=0,
//   busy=0, done=0, err=0; state=IDLE; byte counter=0; word counter=0.
// - All outputs registered. Async reset is valid mid-load: everything returns to reset
//   values immediately; partial word is discarded; already-written words stay in memory.
// - FSM states: IDLE, LOAD, WRITE, DONE.
//   IDLE: start & num_words==0 -> DONE. start & num_words>2**ADDR_WIDTH -> err=1, stay IDLE.
//         start otherwise -> LOAD, word counter=0, byte counter=0, err=0.
//   LOAD: byte_ready=1. On each transfer, byte k (k=0..3) goes to mem_wdata[8k+7:8k].
//         On 4th byte: byte_ready drops the next cycle, go to WRITE.
//   WRITE: exactly one cycle, mem_we=1, mem_addr=word counter, mem_wdata=assembled word,
//         byte_ready=0. Next: word counter+1; if it equals num_words -> DONE, else LOAD.
//   DONE: done=1, core_rst_n=1, byte_ready=0. start (any num_words) re-enters the IDLE
//         start decision in the same cycle: done=0 and core_rst_n=0 on next cycle.
// - Throughput: 5 cycles per word minimum (4 byte beats + 1 write cycle).
// - Latency: 4th byte accepted at edge N -> mem_we high in cycle N+1 -> if last word,
//   done=1 and core_rst_n=1 from cycle N+2.
// - start is ignored while busy. Bytes offered in IDLE, WRITE or DONE are not accepted
//   (byte_ready=0); upstream must hold them.
// - num_words == 2**ADDR_WIDTH is legal: last write at address 2**ADDR_WIDTH-1; no wrap.
// - core_rst_n only rises in DONE; it never pulses during a load.
// TESTING
// 1 Reset, start num_words=1, bytes 13,00,00,00 back-to-back -> one write addr 0
//   data 0x00000013; done=1 and core_rst_n=1 two cycles after 4th byte.
// 2 num_words=4, bytes from a 16-byte image with byte_valid toggling every other cycle ->
//   writes addr 0..3 in order with correct little-endian words; exactly 4 mem_we pulses.
// 3 start with num_words=0 -> DONE next cycle, no mem_we, core_rst_n=1.
// 4 ADDR_WIDTH=2, num_words=5 -> err=1, stays IDLE, byte_ready=0, core_rst_n=0;
//   then start num_words=4 -> err clears, load completes to addr 3.
// 5 Assert rst_n low after 6 bytes of a 2-word load -> all outputs at reset values
//   immediately; new start num_words=1 writes addr 0 from fresh bytes only.
// 6 In DONE, pulse start num_words=1 -> core_rst_n=0 next cycle; start pulses while busy
//   have no effect.

Source files
------------

// File: rtl/instr_mem_loader_if.sv
// Boot-loader bus bundle.
// Carries the load command (start/num_words), the upstream byte stream
// (byte_valid/byte_data/byte_ready), the instruction-memory write port
// (mem_we/mem_addr/mem_wdata) and the core reset plus status flags.
//   master : the loader itself (drives byte_ready, memory writes, core reset, status)
//   slave  : the surrounding system (drives command and byte stream)
interface instr_mem_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  start;
  logic [ADDR_WIDTH:0]   num_words;
  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  core_rst_n;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    input  start, num_words, byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata, core_rst_n, busy, done, err
  );

  modport slave (
    output start, num_words, byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata, core_rst_n, busy, done, err
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Boot-time instruction-memory loader.
// Packs an incoming byte stream little-endian into 32-bit words, writes them
// to consecutive word addresses starting at 0, and holds the core in reset
// until the whole image has been written.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : instr_mem_loader_if.master (command, byte stream, memory write
//            port, core_rst_n, busy/done/err status); all outputs registered
module instr_mem_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_mem_loader_if.master  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  // Largest legal image: exactly fills the memory.
  localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t              state;
  logic [1:0]          byte_cnt;
  logic [ADDR_WIDTH:0] word_cnt;
  logic [ADDR_WIDTH:0] num_words_q;
  logic [ADDR_WIDTH:0] word_cnt_inc;
  logic                start_ok;

  assign word_cnt_inc = word_cnt + (ADDR_WIDTH+1)'(1);
  // start is only honoured when no load is in flight.
  assign start_ok     = bus.start && (state == IDLE || state == DONE);

  // NOTE: all state and outputs use non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      byte_cnt       <= '0;
      word_cnt       <= '0;
      num_words_q    <= '0;
      bus.byte_ready <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.core_rst_n <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.err        <= 1'b0;
    end else begin
      // Write strobe is a single-cycle pulse unless WRITE is entered below.
      bus.mem_we <= 1'b0;

      if (start_ok) begin
        if (bus.num_words == '0) begin
          // Empty image: nothing to write, release the core straight away.
          state          <= DONE;
          bus.done       <= 1'b1;
          bus.core_rst_n <= 1'b1;
          bus.err        <= 1'b0;
        end else if (bus.num_words > MAX_WORDS) begin
          state          <= IDLE;
          bus.err        <= 1'b1;
          bus.done       <= 1'b0;
          bus.core_rst_n <= 1'b0;
        end else begin
          state          <= LOAD;
          num_words_q    <= bus.num_words;
          word_cnt       <= '0;
          byte_cnt       <= '0;
          bus.err        <= 1'b0;
          bus.done       <= 1'b0;
          bus.core_rst_n <= 1'b0;
          bus.busy       <= 1'b1;
          bus.byte_ready <= 1'b1;
        end
      end else begin
        case (state)
          LOAD: begin
            if (bus.byte_valid && bus.byte_ready) begin
              // Every lane is overwritten per word, so no clearing between words.
              bus.mem_wdata[{byte_cnt, 3'b000} +: 8] <= bus.byte_data;
              byte_cnt <= byte_cnt + 2'd1;
              if (byte_cnt == 2'd3) begin
                state          <= WRITE;
                bus.byte_ready <= 1'b0;
                bus.mem_we     <= 1'b1;
                bus.mem_addr   <= word_cnt[ADDR_WIDTH-1:0];
              end
            end
          end
          WRITE: begin
            word_cnt <= word_cnt_inc;
            if (word_cnt_inc == num_words_q) begin
              state          <= DONE;
              bus.busy       <= 1'b0;
              bus.done       <= 1'b1;
              bus.core_rst_n <= 1'b1;
            end else begin
              state          <= LOAD;
              bus.byte_ready <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed testbench for instr_mem_loader: a 10-bit-address instance for most
// scenarios and a 2-bit-address instance for the size-limit scenario.
module tb_instr_mem_loader;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_mem_loader_if #(.ADDR_WIDTH(10)) bus ();
  instr_mem_loader_if #(.ADDR_WIDTH(2))  bus2 ();

  instr_mem_loader #(.ADDR_WIDTH(10)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  instr_mem_loader #(.ADDR_WIDTH(2))  dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  int vectors    = 0;
  int miscompares = 0;

  // Write log and core-reset glitch monitor, sampled mid-cycle.
  int          wr_cnt = 0;
  int          wr2_cnt = 0;
  int          rst_glitch = 0;
  logic [9:0]  wr_addr [256];
  logic [31:0] wr_data [256];
  logic [1:0]  wr2_addr [16];
  logic [31:0] wr2_data [16];

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_addr[wr_cnt[7:0]] = bus.mem_addr;
      wr_data[wr_cnt[7:0]] = bus.mem_wdata;
      wr_cnt++;
    end
    if (bus2.mem_we === 1'b1) begin
      wr2_addr[wr2_cnt[3:0]] = bus2.mem_addr;
      wr2_data[wr2_cnt[3:0]] = bus2.mem_wdata;
      wr2_cnt++;
    end
    if (bus.busy === 1'b1 && bus.core_rst_n === 1'b1) rst_glitch++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input bit sel, input int n);
    if (sel) begin
      bus2.start = 1'b1; bus2.num_words = n[2:0];
    end else begin
      bus.start = 1'b1;  bus.num_words = n[10:0];
    end
    tick();
    bus.start  = 1'b0;
    bus2.start = 1'b0;
  endtask

  // Offer one byte after idle_before cycles of byte_valid low; hold until accepted.
  task automatic send_byte(input bit sel, input logic [7:0] b, input int idle_before);
    bit acc = 1'b0;
    bit rdy;
    for (int i = 0; i < idle_before; i++) tick();
    if (sel) begin bus2.byte_valid = 1'b1; bus2.byte_data = b; end
    else     begin bus.byte_valid  = 1'b1; bus.byte_data  = b; end
    for (int i = 0; i < 20; i++) begin
      rdy = sel ? bus2.byte_ready : bus.byte_ready;
      tick();
      if (rdy) begin acc = 1'b1; break; end
    end
    bus.byte_valid  = 1'b0;
    bus2.byte_valid = 1'b0;
    if (!acc) begin
      $display("FAIL byte_accept: byte %h not accepted within 20 cycles", b);
      miscompares++;
      vectors++;
    end
  endtask

  task automatic wait_done(input bit sel);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if ((sel ? bus2.done : bus.done) === 1'b1) begin seen = 1'b1; break; end
      tick();
    end
    vectors++;
    if (!seen) begin
      $display("FAIL done_wait: done got 0 want 1 within 40 cycles");
      miscompares++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;  bus.num_words = '0;  bus.byte_valid = 1'b0;  bus.byte_data = '0;
    bus2.start = 1'b0; bus2.num_words = '0; bus2.byte_valid = 1'b0; bus2.byte_data = '0;
    #2;
    vectors++;
    if ({bus.byte_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.core_rst_n,
         bus.busy, bus.done, bus.err} !== '0) begin
      $display("FAIL reset_outputs: got rdy=%b we=%b addr=%h data=%h crst=%b busy=%b done=%b err=%b want all 0",
               bus.byte_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.core_rst_n,
               bus.busy, bus.done, bus.err);
      miscompares++;
    end
    vectors++;
    if ({bus2.byte_ready, bus2.mem_we, bus2.mem_addr, bus2.mem_wdata, bus2.core_rst_n,
         bus2.busy, bus2.done, bus2.err} !== '0) begin
      $display("FAIL reset_outputs_aw2: got nonzero outputs want all 0");
      miscompares++;
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_word();
    int base = wr_cnt;
    do_start(0, 1);
    vectors++;
    if (bus.busy !== 1'b1 || bus.byte_ready !== 1'b1) begin
      $display("FAIL start_load: got busy=%b rdy=%b want 1 1", bus.busy, bus.byte_ready);
      miscompares++;
    end
    send_byte(0, 8'h13, 0);
    send_byte(0, 8'h00, 0);
    send_byte(0, 8'h00, 0);
    send_byte(0, 8'h00, 0);
    // Edge N just passed: write cycle, not yet done.
    vectors++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 10'd0 || bus.mem_wdata !== 32'h0000_0013) begin
      $display("FAIL single_write: got we=%b addr=%h data=%h want 1 000 00000013",
               bus.mem_we, bus.mem_addr, bus.mem_wdata);
      miscompares++;
    end
    vectors++;
    if (bus.done !== 1'b0 || bus.byte_ready !== 1'b0) begin
      $display("FAIL single_write_state: got done=%b rdy=%b want 0 0", bus.done, bus.byte_ready);
      miscompares++;
    end
    tick();
    vectors++;
    if (bus.done !== 1'b1 || bus.core_rst_n !== 1'b1 || bus.busy !== 1'b0 || bus.mem_we !== 1'b0) begin
      $display("FAIL single_done: got done=%b crst=%b busy=%b we=%b want 1 1 0 0",
               bus.done, bus.core_rst_n, bus.busy, bus.mem_we);
      miscompares++;
    end
    tick();
    vectors++;
    if (wr_cnt - base !== 1) begin
      $display("FAIL single_count: got %0d writes want 1", wr_cnt - base);
      miscompares++;
    end
  endtask

  task automatic test_four_words();
    logic [7:0]  img [16] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                              8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    logic [31:0] exp [4]  = '{32'h4433_2211, 32'h8877_6655, 32'hCCBB_AA99, 32'hEFBE_ADDE};
    int base = wr_cnt;
    // Restart straight from DONE.
    do_start(0, 4);
    vectors++;
    if (bus.core_rst_n !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      $display("FAIL restart4: got crst=%b done=%b busy=%b want 0 0 1",
               bus.core_rst_n, bus.done, bus.busy);
      miscompares++;
    end
    for (int i = 0; i < 16; i++) send_byte(0, img[i], 1);
    wait_done(0);
    tick();
    vectors++;
    if (wr_cnt - base !== 4) begin
      $display("FAIL four_count: got %0d writes want 4", wr_cnt - base);
      miscompares++;
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (wr_addr[(base + i) % 256] !== 10'(i) || wr_data[(base + i) % 256] !== exp[i]) begin
        $display("FAIL four_word%0d: got addr=%h data=%h want %h %h",
                 i, wr_addr[(base + i) % 256], wr_data[(base + i) % 256], 10'(i), exp[i]);
        miscompares++;
      end
    end
    vectors++;
    if (rst_glitch !== 0) begin
      $display("FAIL core_rst_during_load: got %0d cycles want 0", rst_glitch);
      miscompares++;
    end
  endtask

  task automatic test_zero_words();
    int base;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    base = wr_cnt;
    do_start(0, 0);
    vectors++;
    if (bus.done !== 1'b1 || bus.core_rst_n !== 1'b1 || bus.busy !== 1'b0 || bus.err !== 1'b0) begin
      $display("FAIL zero_done: got done=%b crst=%b busy=%b err=%b want 1 1 0 0",
               bus.done, bus.core_rst_n, bus.busy, bus.err);
      miscompares++;
    end
    tick();
    tick();
    vectors++;
    if (wr_cnt - base !== 0) begin
      $display("FAIL zero_writes: got %0d writes want 0", wr_cnt - base);
      miscompares++;
    end
  endtask

  task automatic test_overflow();
    int base = wr2_cnt;
    logic [31:0] exp [4] = '{32'h0302_0100, 32'h0706_0504, 32'h0B0A_0908, 32'h0F0E_0D0C};
    do_start(1, 5);
    vectors++;
    if (bus2.err !== 1'b1 || bus2.busy !== 1'b0 || bus2.byte_ready !== 1'b0 ||
        bus2.core_rst_n !== 1'b0 || bus2.done !== 1'b0) begin
      $display("FAIL overflow_err: got err=%b busy=%b rdy=%b crst=%b done=%b want 1 0 0 0 0",
               bus2.err, bus2.busy, bus2.byte_ready, bus2.core_rst_n, bus2.done);
      miscompares++;
    end
    bus2.byte_valid = 1'b1;
    bus2.byte_data  = 8'h55;
    tick();
    bus2.byte_valid = 1'b0;
    vectors++;
    if (bus2.err !== 1'b1 || bus2.byte_ready !== 1'b0 || bus2.busy !== 1'b0) begin
      $display("FAIL overflow_sticky: got err=%b rdy=%b busy=%b want 1 0 0",
               bus2.err, bus2.byte_ready, bus2.busy);
      miscompares++;
    end
    do_start(1, 4);
    vectors++;
    if (bus2.err !== 1'b0 || bus2.busy !== 1'b1) begin
      $display("FAIL overflow_clear: got err=%b busy=%b want 0 1", bus2.err, bus2.busy);
      miscompares++;
    end
    for (int i = 0; i < 16; i++) send_byte(1, 8'(i), 0);
    wait_done(1);
    tick();
    vectors++;
    if (wr2_cnt - base !== 4) begin
      $display("FAIL full_count: got %0d writes want 4", wr2_cnt - base);
      miscompares++;
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (wr2_addr[(base + i) % 16] !== 2'(i) || wr2_data[(base + i) % 16] !== exp[i]) begin
        $display("FAIL full_word%0d: got addr=%h data=%h want %h %h",
                 i, wr2_addr[(base + i) % 16], wr2_data[(base + i) % 16], 2'(i), exp[i]);
        miscompares++;
      end
    end
  endtask

  task automatic test_reset_mid_load();
    int base;
    do_start(0, 2);
    for (int i = 0; i < 6; i++) send_byte(0, 8'hA0 + 8'(i), 0);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.byte_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.core_rst_n,
         bus.busy, bus.done, bus.err} !== '0) begin
      $display("FAIL midload_reset: got rdy=%b we=%b addr=%h data=%h crst=%b busy=%b done=%b want all 0",
               bus.byte_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.core_rst_n,
               bus.busy, bus.done);
      miscompares++;
    end
    tick();
    rst_n = 1'b1;
    tick();
    base = wr_cnt;
    do_start(0, 1);
    send_byte(0, 8'h05, 0);
    send_byte(0, 8'h06, 0);
    send_byte(0, 8'h07, 0);
    send_byte(0, 8'h08, 0);
    wait_done(0);
    vectors++;
    if (wr_cnt - base !== 1 || wr_addr[base % 256] !== 10'd0 || wr_data[base % 256] !== 32'h0807_0605) begin
      $display("FAIL fresh_load: got n=%0d addr=%h data=%h want 1 000 08070605",
               wr_cnt - base, wr_addr[base % 256], wr_data[base % 256]);
      miscompares++;
    end
  endtask

  task automatic test_restart_from_done();
    int base = wr_cnt;
    do_start(0, 1);
    vectors++;
    if (bus.core_rst_n !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      $display("FAIL done_restart: got crst=%b done=%b busy=%b want 0 0 1",
               bus.core_rst_n, bus.done, bus.busy);
      miscompares++;
    end
    do_start(0, 3);  // ignored: busy
    send_byte(0, 8'hEF, 0);
    send_byte(0, 8'hBE, 0);
    do_start(0, 0);  // ignored: busy
    vectors++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.core_rst_n !== 1'b0) begin
      $display("FAIL busy_start_ignored: got busy=%b done=%b crst=%b want 1 0 0",
               bus.busy, bus.done, bus.core_rst_n);
      miscompares++;
    end
    send_byte(0, 8'hAD, 0);
    send_byte(0, 8'hDE, 0);
    vectors++;
    if (bus.mem_we !== 1'b1 || bus.mem_wdata !== 32'hDEAD_BEEF || bus.mem_addr !== 10'd0) begin
      $display("FAIL restart_write: got we=%b addr=%h data=%h want 1 000 deadbeef",
               bus.mem_we, bus.mem_addr, bus.mem_wdata);
      miscompares++;
    end
    do_start(0, 3);  // lands in the WRITE cycle: ignored
    vectors++;
    if (bus.done !== 1'b1 || bus.core_rst_n !== 1'b1 || bus.busy !== 1'b0) begin
      $display("FAIL restart_done: got done=%b crst=%b busy=%b want 1 1 0",
               bus.done, bus.core_rst_n, bus.busy);
      miscompares++;
    end
    tick();
    tick();
    vectors++;
    if (wr_cnt - base !== 1 || rst_glitch !== 0 || bus.done !== 1'b1) begin
      $display("FAIL restart_count: got writes=%0d glitch=%0d done=%b want 1 0 1",
               wr_cnt - base, rst_glitch, bus.done);
      miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_four_words();
    test_zero_words();
    test_overflow();
    test_reset_mid_load();
    test_restart_from_done();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
